// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: access sizes, FSM states,
// the IO address map and the response bookkeeping record.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    SPLIT,
    RESP
  } state_e;

  localparam logic [11:0] OUT_BASE = 12'h800;
  localparam logic [11:0] IN_ADDR  = 12'h900;

  localparam int OUT_LCD  = 0;
  localparam int OUT_LEDG = 1;
  localparam int OUT_LEDR = 2;
  localparam int OUT_HEX0 = 3;
  localparam int OUT_HEX1 = 4;
  localparam int OUT_HEX2 = 5;
  localparam int OUT_HEX3 = 6;
  localparam int OUT_HEX4 = 7;
  localparam int OUT_HEX5 = 8;
  localparam int OUT_HEX6 = 9;
  localparam int OUT_HEX7 = 10;

  typedef struct packed {
    logic       err;
    logic       load;
    logic       io;
    logic       split;
    logic [1:0] off;
    logic [1:0] sz;
    logic       uns;
  } rsp_t;

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      SZ_W:    return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: places store data/strobes across a two-word window and
// extracts/extends load data from the same window, covering split halves too.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  st_off_i,
  input  logic [1:0]  st_size_i,
  input  logic [31:0] st_data_i,
  output logic [7:0]  st_be_o,
  output logic [63:0] st_data_o,
  input  logic [1:0]  ld_off_i,
  input  logic [1:0]  ld_size_i,
  input  logic        ld_uns_i,
  input  logic [63:0] ld_window_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  mask;
  logic [31:0] shifted;

  // NOTE: every combinational output is given a default first so no path can infer a latch.
  always_comb begin
    mask = 8'h00;
    case (st_size_i)
      SZ_B:    mask = 8'h01;
      SZ_H:    mask = 8'h03;
      SZ_W:    mask = 8'h0F;
      default: mask = 8'h00;
    endcase
    st_be_o   = mask << st_off_i;
    st_data_o = {32'h0, st_data_i} << {st_off_i, 3'b000};

    shifted   = 32'(ld_window_i >> {ld_off_i, 3'b000});
    ld_data_o = shifted;
    case (ld_size_i)
      SZ_B:    ld_data_o = {{24{~ld_uns_i & shifted[7]}}, shifted[7:0]};
      SZ_H:    ld_data_o = {{16{~ld_uns_i & shifted[15]}}, shifted[15:0]};
      default: ld_data_o = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_mem.sv
// Load/store unit with valid/ready request port, byte-lane data RAM, memory-mapped
// IO registers and a two-cycle split path for word-crossing accesses.
module lsu_mem
  import lsu_pkg::*;
#(
  parameter int DMEM_BYTES = 2048,
  parameter int NUM_OUT    = 12,
  parameter int SW_SYNC    = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [1:0]           req_size_i,
  input  logic                 req_unsigned_i,
  input  logic [31:0]          req_addr_i,
  input  logic [31:0]          req_wdata_i,
  output logic                 rsp_valid_o,
  output logic [31:0]          rsp_rdata_o,
  output logic                 rsp_err_o,
  input  logic [31:0]          io_sw_i,
  output logic [32*NUM_OUT-1:0] io_out_o
);

  localparam int DEPTH = DMEM_BYTES / 4;
  localparam int AW    = $clog2(DEPTH);

  state_e         state_q, state_d;
  rsp_t           rsp_q, rsp_d;
  logic [31:0]    io_rdata_q, io_rdata_d;
  logic [AW-1:0]  hi_idx_q, hi_idx_d;
  logic [3:0]     hi_be_q, hi_be_d;
  logic [31:0]    hi_wdata_q, hi_wdata_d;
  logic [31:0]    out_q [NUM_OUT];
  logic [31:0]    out_d [NUM_OUT];
  logic [31:0]    sw_q [SW_SYNC];

  logic [7:0]     mem [4][DEPTH];
  logic [31:0]    ram_rdata_q, lo_rdata_q;
  logic [AW-1:0]  ram_idx;
  logic [3:0]     ram_be;
  logic [31:0]    ram_wdata;
  logic           ram_re;

  logic           accept, in_ram, is_out, is_in, is_split, req_err, word_io;
  logic [11:0]    a12;
  logic [5:0]     out_idx;
  logic [12:0]    end_addr;
  logic [31:0]    out_rd, ld_data;
  logic [7:0]     st_be;
  logic [63:0]    st_data, ld_window;

  assign a12      = req_addr_i[11:0];
  assign out_idx  = a12[7:2];
  assign end_addr = {1'b0, a12} + 13'(size_bytes(req_size_i)) - 13'd1;
  assign in_ram   = (req_addr_i[31:12] == 20'h0) && (size_bytes(req_size_i) != 3'd0)
                    && (end_addr < 13'(DMEM_BYTES));
  assign word_io  = (req_addr_i[31:12] == 20'h0) && (req_size_i == SZ_W) && (a12[1:0] == 2'b00);
  assign is_out   = word_io && ((a12 & 12'hF00) == OUT_BASE) && ({1'b0, out_idx} < 7'(NUM_OUT));
  assign is_in    = word_io && (a12 == IN_ADDR) && !req_we_i;
  assign req_err  = !(in_ram || is_out || is_in);
  assign is_split = in_ram && (({1'b0, a12[1:0]} + size_bytes(req_size_i)) > 3'd4);

  assign req_ready_o = (state_q != SPLIT);
  assign accept      = req_valid_i && req_ready_o;
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_err_o   = rsp_valid_o && rsp_q.err;
  assign ld_window   = rsp_q.split ? {ram_rdata_q, lo_rdata_q} : {32'h0, ram_rdata_q};
  assign rsp_rdata_o = (rsp_valid_o && rsp_q.load && !rsp_q.err)
                       ? (rsp_q.io ? io_rdata_q : ld_data) : 32'h0;

  lsu_lane_align u_align (
    .st_off_i    (a12[1:0]),
    .st_size_i   (req_size_i),
    .st_data_i   (req_wdata_i),
    .st_be_o     (st_be),
    .st_data_o   (st_data),
    .ld_off_i    (rsp_q.off),
    .ld_size_i   (rsp_q.sz),
    .ld_uns_i    (rsp_q.uns),
    .ld_window_i (ld_window),
    .ld_data_o   (ld_data)
  );

  always_comb begin
    state_d    = state_q;
    rsp_d      = rsp_q;
    io_rdata_d = io_rdata_q;
    hi_idx_d   = hi_idx_q;
    hi_be_d    = hi_be_q;
    hi_wdata_d = hi_wdata_q;
    out_d      = out_q;
    ram_idx    = req_addr_i[AW+1:2];
    ram_be     = 4'b0000;
    ram_wdata  = st_data[31:0];
    ram_re     = 1'b0;
    out_rd     = 32'h0;
    for (int n = 0; n < NUM_OUT; n++)
      if (out_idx == 6'(n)) out_rd = out_q[n];

    unique case (state_q)
      SPLIT: begin
        state_d   = RESP;
        ram_idx   = hi_idx_q;
        ram_be    = rsp_q.load ? 4'b0000 : hi_be_q;
        ram_wdata = hi_wdata_q;
        ram_re    = rsp_q.load;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d    = is_split ? SPLIT : RESP;
      rsp_d      = '{err: req_err, load: !req_we_i, io: is_out || is_in, split: is_split,
                     off: a12[1:0], sz: req_size_i, uns: req_unsigned_i};
      io_rdata_d = is_in ? sw_q[SW_SYNC-1] : out_rd;
      hi_idx_d   = req_addr_i[AW+1:2] + AW'(1);
      hi_be_d    = st_be[7:4];
      hi_wdata_d = st_data[63:32];
      if (in_ram) begin
        ram_re = !req_we_i;
        ram_be = req_we_i ? st_be[3:0] : 4'b0000;
      end
      if (is_out && req_we_i)
        for (int n = 0; n < NUM_OUT; n++)
          if (out_idx == 6'(n)) out_d[n] = req_wdata_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      rsp_q      <= '0;
      io_rdata_q <= '0;
      hi_idx_q   <= '0;
      hi_be_q    <= '0;
      hi_wdata_q <= '0;
      for (int n = 0; n < NUM_OUT; n++) out_q[n] <= '0;
      for (int s = 0; s < SW_SYNC; s++) sw_q[s] <= '0;
    end else begin
      state_q    <= state_d;
      rsp_q      <= rsp_d;
      io_rdata_q <= io_rdata_d;
      hi_idx_q   <= hi_idx_d;
      hi_be_q    <= hi_be_d;
      hi_wdata_q <= hi_wdata_d;
      out_q      <= out_d;
      sw_q[0]    <= io_sw_i;
      for (int s = 1; s < SW_SYNC; s++) sw_q[s] <= sw_q[s-1];
    end
  end

  // NOTE: RAM and its read register are deliberately not reset; responses are gated instead.
  // Writes land at the accepting edge, so a following load never races its store: no bypass.
  always_ff @(posedge clk_i) begin
    for (int l = 0; l < 4; l++)
      if (ram_be[l]) mem[l][ram_idx] <= ram_wdata[8*l +: 8];
    if (ram_re)
      ram_rdata_q <= {mem[3][ram_idx], mem[2][ram_idx], mem[1][ram_idx], mem[0][ram_idx]};
    if (state_q == SPLIT) lo_rdata_q <= ram_rdata_q;
  end

  for (genvar n = 0; n < NUM_OUT; n++) begin : g_out
    assign io_out_o[32*n +: 32] = out_q[n];
  end

endmodule

// File: tb/tb_lsu_mem.sv
// Self-checking bench for lsu_mem: table of accesses plus hand-written split,
// IO, synchroniser and mid-split reset sequences, checked through a scoreboard.
module tb_lsu_mem;
  import lsu_pkg::*;

  localparam int DMEM_BYTES = 2048;
  localparam int NUM_OUT    = 12;
  localparam int SW_SYNC    = 2;

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic                  req_valid_i, req_ready_o, req_we_i, req_unsigned_i;
  logic [1:0]            req_size_i;
  logic [31:0]           req_addr_i, req_wdata_i;
  logic                  rsp_valid_o, rsp_err_o;
  logic [31:0]           rsp_rdata_o, io_sw_i;
  logic [32*NUM_OUT-1:0] io_out_o;

  lsu_mem #(.DMEM_BYTES(DMEM_BYTES), .NUM_OUT(NUM_OUT), .SW_SYNC(SW_SYNC)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .io_sw_i(io_sw_i), .io_out_o(io_out_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    exp_t e;
    if (rsp_valid_o) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", {31'b0, rsp_valid_o}, 32'd0);
      end else begin
        e = sb.pop_front();
        check({e.name, " rdata"}, rsp_rdata_o, e.rdata);
        check({e.name, " err"}, {31'b0, rsp_err_o}, {31'b0, e.err});
        check({e.name, " latency"}, cyc, e.due);
      end
    end
  end

  // Called just after a negedge; returns one negedge after the accepting edge.
  task automatic do_req(input string name, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input logic err, input int lat);
    int waited;
    waited         = 0;
    req_valid_i    = 1'b1;
    req_we_i       = we;
    req_size_i     = size;
    req_unsigned_i = uns;
    req_addr_i     = addr;
    req_wdata_i    = wdata;
    while (!req_ready_o && waited < 10) begin
      @(negedge clk_i);
      waited++;
    end
    if (!req_ready_o) check({name, " ready_timeout"}, {31'b0, req_ready_o}, 32'd1);
    else sb.push_back('{name: name, rdata: rdata, err: err, due: cyc + lat});
    @(negedge clk_i);
  endtask

  task automatic idle(input int n);
    req_valid_i = 1'b0;
    repeat (n) @(negedge clk_i);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " ready"}, {31'b0, req_ready_o}, 32'd1);
    check({tag, " rsp_valid"}, {31'b0, rsp_valid_o}, 32'd0);
    check({tag, " rsp_rdata"}, rsp_rdata_o, 32'd0);
    check({tag, " rsp_err"}, {31'b0, rsp_err_o}, 32'd0);
    for (int n = 0; n < NUM_OUT; n++)
      check($sformatf("%s io_out[%0d]", tag, n), io_out_o[32*n +: 32], 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int waited;
    vecs.push_back('{"sw_010",      1, SZ_W, 0, 32'h010,  32'hDEADBEEF, 32'h0,        0, 1});
    vecs.push_back('{"lw_010",      0, SZ_W, 0, 32'h010,  32'h0,        32'hDEADBEEF, 0, 1});
    vecs.push_back('{"lbu_013",     0, SZ_B, 1, 32'h013,  32'h0,        32'h000000DE, 0, 1});
    vecs.push_back('{"lb_013",      0, SZ_B, 0, 32'h013,  32'h0,        32'hFFFFFFDE, 0, 1});
    vecs.push_back('{"lh_012",      0, SZ_H, 0, 32'h012,  32'h0,        32'hFFFFDEAD, 0, 1});
    vecs.push_back('{"lhu_010",     0, SZ_H, 1, 32'h010,  32'h0,        32'h0000BEEF, 0, 1});
    vecs.push_back('{"sw_020",      1, SZ_W, 0, 32'h020,  32'h0,        32'h0,        0, 1});
    vecs.push_back('{"sb_021",      1, SZ_B, 0, 32'h021,  32'h123456AB, 32'h0,        0, 1});
    vecs.push_back('{"sh_022",      1, SZ_H, 0, 32'h022,  32'h9999CAFE, 32'h0,        0, 1});
    vecs.push_back('{"lw_020",      0, SZ_W, 0, 32'h020,  32'h0,        32'hCAFEAB00, 0, 1});
    vecs.push_back('{"lh_022",      0, SZ_H, 0, 32'h022,  32'h0,        32'hFFFFCAFE, 0, 1});
    vecs.push_back('{"lhu_022",     0, SZ_H, 1, 32'h022,  32'h0,        32'h0000CAFE, 0, 1});
    vecs.push_back('{"lb_021",      0, SZ_B, 0, 32'h021,  32'h0,        32'hFFFFFFAB, 0, 1});
    vecs.push_back('{"lbu_021",     0, SZ_B, 1, 32'h021,  32'h0,        32'h000000AB, 0, 1});
    vecs.push_back('{"size11_010",  0, 2'b11, 0, 32'h010, 32'h0,        32'h0,        1, 1});
    vecs.push_back('{"sh_02f_split",1, SZ_H, 0, 32'h02F,  32'h1234BBCC, 32'h0,        0, 2});
    vecs.push_back('{"lh_02f_split",0, SZ_H, 0, 32'h02F,  32'h0,        32'hFFFFBBCC, 0, 2});
    vecs.push_back('{"sw_7fc",      1, SZ_W, 0, 32'h7FC,  32'h01020304, 32'h0,        0, 1});
    vecs.push_back('{"lw_7fc",      0, SZ_W, 0, 32'h7FC,  32'h0,        32'h01020304, 0, 1});
    vecs.push_back('{"lb_7ff",      0, SZ_B, 0, 32'h7FF,  32'h0,        32'h00000001, 0, 1});
    vecs.push_back('{"lh_7fe",      0, SZ_H, 0, 32'h7FE,  32'h0,        32'h00000102, 0, 1});
    vecs.push_back('{"lh_7ff_end",  0, SZ_H, 0, 32'h7FF,  32'h0,        32'h0,        1, 1});
    vecs.push_back('{"lw_7fe_end",  0, SZ_W, 0, 32'h7FE,  32'h0,        32'h0,        1, 1});
    vecs.push_back('{"sw_800_lcd",  1, SZ_W, 0, 32'h800,  32'h12345678, 32'h0,        0, 1});
    vecs.push_back('{"lw_800_lcd",  0, SZ_W, 0, 32'h800,  32'h0,        32'h12345678, 0, 1});
    vecs.push_back('{"lw_82c_last", 0, SZ_W, 0, 32'h82C,  32'h0,        32'h0,        0, 1});
    vecs.push_back('{"sw_830_oob",  1, SZ_W, 0, 32'h830,  32'hFFFFFFFF, 32'h0,        1, 1});
    vecs.push_back('{"lb_804",      0, SZ_B, 0, 32'h804,  32'h0,        32'h0,        1, 1});
    vecs.push_back('{"lw_802",      0, SZ_W, 0, 32'h802,  32'h0,        32'h0,        1, 1});
    vecs.push_back('{"sw_900",      1, SZ_W, 0, 32'h900,  32'h1,        32'h0,        1, 1});
    vecs.push_back('{"lw_900",      0, SZ_W, 0, 32'h900,  32'h0,        32'hA5A5A5A5, 0, 1});
    vecs.push_back('{"lw_a00",      0, SZ_W, 0, 32'hA00,  32'h0,        32'h0,        1, 1});
    vecs.push_back('{"lw_1000",     0, SZ_W, 0, 32'h1000, 32'h0,        32'h0,        1, 1});

    rst_i = 1'b1;
    req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'b00; req_unsigned_i = 1'b0;
    req_addr_i = 32'h0; req_wdata_i = 32'h0; io_sw_i = 32'h0;
    repeat (2) @(negedge clk_i);
    check_reset_outputs("reset");
    rst_i   = 1'b0;
    io_sw_i = 32'hA5A5A5A5;
    @(negedge clk_i);

    foreach (vecs[i])
      do_req(vecs[i].name, vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr,
             vecs[i].wdata, vecs[i].rdata, vecs[i].err, vecs[i].lat);
    idle(2);

    // Split word store across 0x00C/0x010, with surrounding bytes preserved.
    do_req("sw_00c", 1, SZ_W, 0, 32'h00C, 32'hA1B2C3D4, 32'h0, 0, 1);
    do_req("sw_00e_split", 1, SZ_W, 0, 32'h00E, 32'h11223344, 32'h0, 0, 2);
    check("split ready_low", {31'b0, req_ready_o}, 32'd0);
    do_req("lw_00e_split", 0, SZ_W, 0, 32'h00E, 32'h0, 32'h11223344, 0, 2);
    do_req("lhu_00f_split", 0, SZ_H, 1, 32'h00F, 32'h0, 32'h00002233, 0, 2);
    do_req("lw_00c_after", 0, SZ_W, 0, 32'h00C, 32'h0, 32'h3344C3D4, 0, 1);
    do_req("lw_010_after", 0, SZ_W, 0, 32'h010, 32'h0, 32'hDEAD1122, 0, 1);
    idle(1);

    // Output register write and rejected half store.
    do_req("sw_804_ledg", 1, SZ_W, 0, 32'h804, 32'h000000FF, 32'h0, 0, 1);
    check("ledg after store", io_out_o[63:32], 32'h000000FF);
    do_req("sh_806_err", 1, SZ_H, 0, 32'h806, 32'h0000ABCD, 32'h0, 1, 1);
    check("ledg after bad store", io_out_o[63:32], 32'h000000FF);
    do_req("lw_804_ledg", 0, SZ_W, 0, 32'h804, 32'h0, 32'h000000FF, 0, 1);

    // Switch change propagates through the synchroniser after SW_SYNC edges.
    io_sw_i = 32'h5A5A5A5A;
    do_req("sw_sync_0", 0, SZ_W, 0, 32'h900, 32'h0, 32'hA5A5A5A5, 0, 1);
    do_req("sw_sync_1", 0, SZ_W, 0, 32'h900, 32'h0, 32'hA5A5A5A5, 0, 1);
    do_req("sw_sync_2", 0, SZ_W, 0, 32'h900, 32'h0, 32'h5A5A5A5A, 0, 1);

    // Reset during the upper half of a split store.
    do_req("sw_004", 1, SZ_W, 0, 32'h004, 32'h0, 32'h0, 0, 1);
    do_req("sw_008", 1, SZ_W, 0, 32'h008, 32'h0, 32'h0, 0, 1);
    req_valid_i = 1'b1; req_we_i = 1'b1; req_size_i = SZ_W; req_unsigned_i = 1'b0;
    req_addr_i = 32'h006; req_wdata_i = 32'h55667788;
    waited = 0;
    while (!req_ready_o && waited < 10) begin
      @(negedge clk_i);
      waited++;
    end
    @(negedge clk_i);
    check("abort ready_low", {31'b0, req_ready_o}, 32'd0);
    rst_i       = 1'b1;
    req_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check_reset_outputs("abort");
    rst_i = 1'b0;
    @(negedge clk_i);
    do_req("lw_004_abort", 0, SZ_W, 0, 32'h004, 32'h0, 32'h77880000, 0, 1);
    do_req("lw_008_abort", 0, SZ_W, 0, 32'h008, 32'h0, 32'h00000000, 0, 1);
    do_req("lw_804_reset", 0, SZ_W, 0, 32'h804, 32'h0, 32'h00000000, 0, 1);
    idle(2);

    waited = 0;
    while (sb.size() != 0 && waited < 20) begin
      @(negedge clk_i);
      waited++;
    end
    check("scoreboard drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
